// File: rtl/deser_pkg.sv
// deser_pkg: shared constants, bit-order type and width helper for the deserializer.
package deser_pkg;
  localparam int DESER_W_MAX = 64;
  typedef enum logic {LSB_FIRST_E = 1'b0, MSB_FIRST_E = 1'b1} bit_order_e;
  function automatic int mod_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/deser_out_reg.sv
// deser_out_reg: one-entry output register with valid/ready; frees its slot in the same cycle it is drained.
module deser_out_reg import deser_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = mod_width(DATA_W)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic [MOD_W-1:0]  mod,
  output logic              data_ready_o,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  input  logic              deser_data_ready_i
);
  assign data_ready_o = ~deser_data_val_o | deser_data_ready_i;
  always_ff @(posedge clk_i or posedge srst_i)
    if (srst_i) begin
      deser_data_o     <= '0;
      deser_data_mod_o <= '0;
      deser_data_val_o <= 1'b0;
    end else if (load) begin
      deser_data_o     <= word;
      deser_data_mod_o <= mod;
      deser_data_val_o <= 1'b1;
    end else if (deser_data_ready_i) begin
      deser_data_val_o <= 1'b0;
    end
  // A load while the held word is still unaccepted would silently drop it.
  a_no_overwrite: assert property (@(posedge clk_i) disable iff (srst_i) load |-> data_ready_o);
endmodule

// File: rtl/deser_par.sv
// deser_par: parametrised serial-to-parallel converter with selectable bit order, flush and backpressure.
module deser_par import deser_pkg::*; #(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = 1'b1,
  parameter int MOD_W     = mod_width(DATA_W)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              data_i,
  input  logic              data_val_i,
  input  logic              flush_i,
  output logic              data_ready_o,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  input  logic              deser_data_ready_i
);
  localparam bit_order_e        ORDER   = MSB_FIRST ? MSB_FIRST_E : LSB_FIRST_E;
  localparam logic [DATA_W-1:0] LSB_ONE = DATA_W'(1);
  localparam logic [DATA_W-1:0] MSB_ONE = LSB_ONE << (DATA_W - 1);
  localparam logic [MOD_W-1:0]  LAST    = MOD_W'(DATA_W - 1);
  logic [MOD_W-1:0]  cnt, cnt_nx;
  logic [DATA_W-1:0] shreg, shreg_nx, sel;
  logic              bit_acc, flush_acc, done;
  assign bit_acc   = data_val_i & data_ready_o;
  assign flush_acc = flush_i & data_ready_o;
  // Bits are written in place rather than shifted, so a flushed partial word already has its unfilled positions at 0.
  always_comb begin
    sel      = ORDER == MSB_FIRST_E ? MSB_ONE >> cnt : LSB_ONE << cnt;
    shreg_nx = bit_acc & data_i ? shreg | sel : shreg;
    cnt_nx   = cnt + MOD_W'(bit_acc);
    done     = (bit_acc & (cnt == LAST)) | (flush_acc & (cnt_nx != '0));
  end
  always_ff @(posedge clk_i or posedge srst_i)
    if (srst_i) begin
      cnt   <= '0;
      shreg <= '0;
    end else begin
      cnt   <= done ? '0 : cnt_nx;
      shreg <= done ? '0 : shreg_nx;
    end
  deser_out_reg #(.DATA_W(DATA_W), .MOD_W(MOD_W)) u_out (
    .clk_i              (clk_i),
    .srst_i             (srst_i),
    .load               (done),
    .word               (shreg_nx),
    .mod                (cnt_nx),
    .data_ready_o       (data_ready_o),
    .deser_data_o       (deser_data_o),
    .deser_data_mod_o   (deser_data_mod_o),
    .deser_data_val_o   (deser_data_val_o),
    .deser_data_ready_i (deser_data_ready_i)
  );
  a_width: assert property (@(posedge clk_i) DATA_W >= 2 && DATA_W <= DESER_W_MAX);
  a_cnt_range: assert property (@(posedge clk_i) disable iff (srst_i) cnt <= LAST);
  a_mod_range: assert property (@(posedge clk_i) disable iff (srst_i)
    deser_data_val_o |-> deser_data_mod_o != '0 && deser_data_mod_o <= MOD_W'(DATA_W));
  a_hold: assert property (@(posedge clk_i) disable iff (srst_i)
    deser_data_val_o & ~deser_data_ready_i |=> deser_data_val_o & $stable(deser_data_o) & $stable(deser_data_mod_o));
endmodule

// File: tb/tb_deser_par.sv
// tb_deser_par: directed checks of deser_par across several widths and bit orders.
module tb_deser_par;
  import deser_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  logic a_d = 0, a_v = 0, a_f = 0, a_r = 1, a_rdy, a_ov;
  logic [15:0] a_q;
  logic [4:0]  a_m;
  logic b_d = 0, b_v = 0, b_f = 0, b_r = 1, b_rdy, b_ov;
  logic [7:0] b_q;
  logic [3:0] b_m;
  logic c_d = 0, c_v = 0, c_f = 0, c_r = 1, c_rdy, c_ov;
  logic [7:0] c_q;
  logic [3:0] c_m;
  logic e_d = 0, e_v = 0, e_f = 0, e_r = 1, e_rdy, e_ov;
  logic [3:0] e_q;
  logic [2:0] e_m;
  deser_par #(.DATA_W(16), .MSB_FIRST(1'b1)) u_a (.clk_i(clk), .srst_i(rst), .data_i(a_d), .data_val_i(a_v),
    .flush_i(a_f), .data_ready_o(a_rdy), .deser_data_o(a_q), .deser_data_mod_o(a_m), .deser_data_val_o(a_ov),
    .deser_data_ready_i(a_r));
  deser_par #(.DATA_W(8), .MSB_FIRST(1'b0)) u_b (.clk_i(clk), .srst_i(rst), .data_i(b_d), .data_val_i(b_v),
    .flush_i(b_f), .data_ready_o(b_rdy), .deser_data_o(b_q), .deser_data_mod_o(b_m), .deser_data_val_o(b_ov),
    .deser_data_ready_i(b_r));
  deser_par #(.DATA_W(8), .MSB_FIRST(1'b1)) u_c (.clk_i(clk), .srst_i(rst), .data_i(c_d), .data_val_i(c_v),
    .flush_i(c_f), .data_ready_o(c_rdy), .deser_data_o(c_q), .deser_data_mod_o(c_m), .deser_data_val_o(c_ov),
    .deser_data_ready_i(c_r));
  deser_par #(.DATA_W(4), .MSB_FIRST(1'b1)) u_e (.clk_i(clk), .srst_i(rst), .data_i(e_d), .data_val_i(e_v),
    .flush_i(e_f), .data_ready_o(e_rdy), .deser_data_o(e_q), .deser_data_mod_o(e_m), .deser_data_val_o(e_ov),
    .deser_data_ready_i(e_r));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    total++; if (a_q !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=%h", a_q, 16'h0); end
    total++; if (a_m !== 5'd0) begin bad++; $display("FAIL reset_mod got=%0d exp=0", a_m); end
    total++; if (a_ov !== 1'b0 || e_ov !== 1'b0) begin bad++; $display("FAIL reset_val got=%b/%b exp=0/0", a_ov, e_ov); end
    total++; if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b/%b exp=1/1", a_rdy, b_rdy); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_msb16;
    logic [15:0] w;
    w = 16'hA5C3;
    a_r = 1'b1;
    for (int k = 0; k < 16; k++) begin
      a_d = w[15-k];
      a_v = 1'b1;
      tick;
      if (k < 15) begin
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL msb16_early_val bit=%0d got=%b exp=0", k, a_ov); end
      end
    end
    a_v = 1'b0;
    total++; if (a_q !== 16'hA5C3) begin bad++; $display("FAIL msb16_data got=%h exp=a5c3", a_q); end
    total++; if (a_m !== 5'd16) begin bad++; $display("FAIL msb16_mod got=%0d exp=16", a_m); end
    total++; if (a_ov !== 1'b1) begin bad++; $display("FAIL msb16_val got=%b exp=1", a_ov); end
    tick;
    total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL msb16_single_pulse got=%b exp=0", a_ov); end
  endtask

  task automatic test_flush_lsb8;
    logic [3:0] bits;
    logic [7:0] w;
    bits = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      b_d = bits[k];
      b_v = 1'b1;
      tick;
    end
    b_v = 1'b0;
    b_f = 1'b1;
    tick;
    b_f = 1'b0;
    total++; if (b_q !== 8'h0D) begin bad++; $display("FAIL flush_data got=%h exp=0d", b_q); end
    total++; if (b_m !== 4'd4) begin bad++; $display("FAIL flush_mod got=%0d exp=4", b_m); end
    total++; if (b_ov !== 1'b1) begin bad++; $display("FAIL flush_val got=%b exp=1", b_ov); end
    tick;
    total++; if (b_ov !== 1'b0) begin bad++; $display("FAIL flush_single_pulse got=%b exp=0", b_ov); end
    b_f = 1'b1;
    tick;
    b_f = 1'b0;
    total++; if (b_ov !== 1'b0) begin bad++; $display("FAIL flush_empty got=%b exp=0", b_ov); end
    tick;
    total++; if (b_ov !== 1'b0) begin bad++; $display("FAIL flush_empty_late got=%b exp=0", b_ov); end
    w = 8'h5A;
    for (int k = 0; k < 8; k++) begin
      b_d = w[k];
      b_v = 1'b1;
      tick;
    end
    b_v = 1'b0;
    total++; if (b_q !== 8'h5A || b_m !== 4'd8 || b_ov !== 1'b1) begin
      bad++; $display("FAIL flush_next_word got=%h/%0d/%b exp=5a/8/1", b_q, b_m, b_ov);
    end
    tick;
  endtask

  task automatic test_flush_full;
    c_r = 1'b1;
    for (int k = 0; k < 8; k++) begin
      c_d = (k < 7);
      c_v = 1'b1;
      c_f = (k == 7);
      tick;
    end
    c_v = 1'b0;
    c_f = 1'b0;
    total++; if (c_q !== 8'hFE) begin bad++; $display("FAIL full_flush_data got=%h exp=fe", c_q); end
    total++; if (c_m !== 4'd8) begin bad++; $display("FAIL full_flush_mod got=%0d exp=8", c_m); end
    total++; if (c_ov !== 1'b1) begin bad++; $display("FAIL full_flush_val got=%b exp=1", c_ov); end
    tick;
    total++; if (c_ov !== 1'b0) begin bad++; $display("FAIL full_flush_pulse got=%b exp=0", c_ov); end
    tick;
    total++; if (c_ov !== 1'b0) begin bad++; $display("FAIL full_flush_no_extra got=%b exp=0", c_ov); end
  endtask

  task automatic test_stall;
    logic [7:0] w, w2;
    w = 8'h3C;
    w2 = 8'hA7;
    c_r = 1'b0;
    for (int k = 0; k < 8; k++) begin
      c_d = w[7-k];
      c_v = 1'b1;
      tick;
    end
    total++; if (c_q !== 8'h3C || c_ov !== 1'b1 || c_rdy !== 1'b0) begin
      bad++; $display("FAIL stall_first got=%h/%b/%b exp=3c/1/0", c_q, c_ov, c_rdy);
    end
    c_d = w2[7];
    for (int k = 0; k < 5; k++) begin
      tick;
      total++; if (c_rdy !== 1'b0 || c_q !== 8'h3C || c_ov !== 1'b1 || c_m !== 4'd8) begin
        bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%b/%0d exp=0/3c/1/8", k, c_rdy, c_q, c_ov, c_m);
      end
    end
    c_r = 1'b1;
    #1;
    total++; if (c_rdy !== 1'b1) begin bad++; $display("FAIL stall_ready_comb got=%b exp=1", c_rdy); end
    tick;
    total++; if (c_ov !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", c_ov); end
    for (int k = 1; k < 8; k++) begin
      c_d = w2[7-k];
      tick;
    end
    c_v = 1'b0;
    total++; if (c_q !== 8'hA7 || c_m !== 4'd8 || c_ov !== 1'b1) begin
      bad++; $display("FAIL stall_next_word got=%h/%0d/%b exp=a7/8/1", c_q, c_m, c_ov);
    end
    tick;
  endtask

  task automatic test_async_reset;
    logic [15:0] w;
    a_r = 1'b1;
    for (int k = 0; k < 9; k++) begin
      a_d = 1'b1;
      a_v = 1'b1;
      tick;
    end
    a_v = 1'b0;
    #3 rst = 1'b1;
    #1;
    total++; if (a_q !== 16'h0 || a_m !== 5'd0 || a_ov !== 1'b0 || a_rdy !== 1'b1) begin
      bad++; $display("FAIL async_reset got=%h/%0d/%b/%b exp=0000/0/0/1", a_q, a_m, a_ov, a_rdy);
    end
    #2 rst = 1'b0;
    w = 16'h1234;
    for (int k = 0; k < 16; k++) begin
      a_d = w[15-k];
      a_v = 1'b1;
      tick;
    end
    a_v = 1'b0;
    total++; if (a_q !== 16'h1234 || a_m !== 5'd16 || a_ov !== 1'b1) begin
      bad++; $display("FAIL reset_next_word got=%h/%0d/%b exp=1234/16/1", a_q, a_m, a_ov);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [11:0] s;
    logic [3:0] exp_n;
    s = 12'h96F;
    e_r = 1'b1;
    for (int k = 0; k < 12; k++) begin
      e_d = s[11-k];
      e_v = 1'b1;
      tick;
      exp_n = s[11-4*(k/4) -: 4];
      if (k % 4 == 3) begin
        total++; if (e_ov !== 1'b1 || e_q !== exp_n || e_m !== 3'd4) begin
          bad++; $display("FAIL b2b_word idx=%0d got=%b/%h/%0d exp=1/%h/4", k / 4, e_ov, e_q, e_m, exp_n);
        end
      end else begin
        total++; if (e_ov !== 1'b0) begin bad++; $display("FAIL b2b_gap bit=%0d got=%b exp=0", k, e_ov); end
      end
    end
    e_d = 1'b1;
    e_f = 1'b1;
    tick;
    e_v = 1'b0;
    e_f = 1'b0;
    total++; if (e_ov !== 1'b1 || e_q !== 4'h8 || e_m !== 3'd1) begin
      bad++; $display("FAIL b2b_reload got=%b/%h/%0d exp=1/8/1", e_ov, e_q, e_m);
    end
    tick;
    total++; if (e_ov !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", e_ov); end
  endtask

  initial begin
    test_reset;
    test_msb16;
    test_flush_lsb8;
    test_flush_full;
    test_stall;
    test_async_reset;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
